interp_seq_ctrl: RTL and testbench

- Sequencer for the pilot-interpolation datapath (real and imag halves share one control set).
- On `start`, it steps that datapath through a fixed schedule of steps:
  - 2 preparation steps load the scaled-estimate registers E, 2E and 5E.
  - 6 emit steps each present one pair of equaliser taps (h_eqlz_1/h_eqlz_2), giving 12 subcarriers.
- Sits between the LS pilot estimator (source of E1..E4) and the equaliser, which applies backpressure via `out_ready`.

---
 rtl/interp_ctrl_pkg.sv | 60 ++++++
 rtl/interp_step_decode.sv | 28 ++
 rtl/interp_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_interp_seq_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/interp_ctrl_pkg.sv
// Shared types, select codes and step tables for the pilot-interpolation sequencer.
// Combinational constants only; no latency, no flow control.
package interp_ctrl_pkg;

    localparam int NUM_PREP = 2;
    localparam int NUM_OUT  = 6;
    localparam int STEP_W   = 3;
    localparam int STALL_W  = 16;

    // Adder operand mux codes (E1..E4 are the pilot estimates after order select)
    localparam logic [2:0] OP_ZERO = 3'd0;
    localparam logic [2:0] OP_E1   = 3'd1;
    localparam logic [2:0] OP_E2   = 3'd2;
    localparam logic [2:0] OP_E3   = 3'd3;
    localparam logic [2:0] OP_E4   = 3'd4;
    localparam logic [2:0] OP_RE   = 3'd5;
    localparam logic [2:0] OP_R2E  = 3'd6;
    localparam logic [2:0] OP_R5E  = 3'd7;

    // Output mux codes
    localparam logic [1:0] H_ZERO  = 2'd0;
    localparam logic [1:0] H_SUM1  = 2'd1;
    localparam logic [1:0] H_SUM2  = 2'd2;
    localparam logic [1:0] H_PILOT = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        EMIT = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0] s1a;
        logic [2:0] s1b;
        logic [2:0] s2a;
        logic [2:0] s2b;
        logic [1:0] s_h1;
        logic [1:0] s_h2;
        logic       en_E;
        logic       en_2E;
        logic       en_5E;
    } ctrl_t;

    // Row 0 forms the one-third step E and 2E; row 1 builds 5E = 2E + 2E + E from them.
    localparam ctrl_t PREP_TBL [NUM_PREP] = '{
        '{OP_E2,  OP_E1,  OP_E2, OP_E1,   H_ZERO, H_ZERO, 1'b1, 1'b1, 1'b0},
        '{OP_R2E, OP_R2E, OP_RE, OP_ZERO, H_ZERO, H_ZERO, 1'b0, 1'b0, 1'b1}
    };

    // Each row yields two subcarriers: pilot plus 0, 1/3 or 2/3 of the gap; last row extrapolates via 5E.
    localparam ctrl_t EMIT_TBL [NUM_OUT] = '{
        '{OP_E1, OP_ZERO, OP_E1, OP_RE,   H_SUM1, H_SUM2, 1'b0, 1'b0, 1'b0},
        '{OP_E1, OP_R2E,  OP_E2, OP_ZERO, H_SUM1, H_SUM2, 1'b0, 1'b0, 1'b0},
        '{OP_E2, OP_RE,   OP_E2, OP_R2E,  H_SUM1, H_SUM2, 1'b0, 1'b0, 1'b0},
        '{OP_E3, OP_ZERO, OP_E3, OP_RE,   H_SUM1, H_SUM2, 1'b0, 1'b0, 1'b0},
        '{OP_E3, OP_R2E,  OP_E4, OP_ZERO, H_SUM1, H_SUM2, 1'b0, 1'b0, 1'b0},
        '{OP_E4, OP_RE,   OP_E4, OP_R5E,  H_SUM1, H_SUM2, 1'b0, 1'b0, 1'b0}
    };

endpackage

// File: rtl/interp_step_decode.sv
// Maps (state, step) to the datapath control word; purely combinational, zero latency,
// no flow control. Outside PREP/EMIT the word is all zeros.
module interp_step_decode
    import interp_ctrl_pkg::*;
(
    input  state_t              state,
    input  logic [STEP_W-1:0]   step,
    output ctrl_t               ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            PREP: begin
                for (int i = 0; i < NUM_PREP; i++) begin
                    if (step == STEP_W'(i)) ctrl = PREP_TBL[i];
                end
            end
            EMIT: begin
                for (int i = 0; i < NUM_OUT; i++) begin
                    if (step == STEP_W'(i)) ctrl = EMIT_TBL[i];
                end
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/interp_seq_ctrl.sv
// Pilot-interpolation sequencer: first tap pair NUM_PREP+1 cycles after start; out_ready low
// holds the current pair and its selects. INTERP_SEQ_STALL_CNT_EN adds the stall_cnt port.
module interp_seq_ctrl
    import interp_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                shift_sel,
    input  logic                out_ready,
    output logic                busy,
    output logic                out_valid,
    output logic [STEP_W-1:0]   pair_idx,
    output logic                done,
    output logic                start_err,
    output logic [2:0]          s1a,
    output logic [2:0]          s1b,
    output logic [2:0]          s2a,
    output logic [2:0]          s2b,
    output logic [1:0]          s_h1,
    output logic [1:0]          s_h2,
    output logic                sel_est,
    output logic                en_reg_E,
    output logic                en_reg_2E,
    output logic                en_reg_5E
`ifdef INTERP_SEQ_STALL_CNT_EN
    ,
    output logic [STALL_W-1:0]  stall_cnt
`endif
);

    localparam logic [STEP_W-1:0] LAST_PREP = STEP_W'(NUM_PREP - 1);
    localparam logic [STEP_W-1:0] LAST_OUT  = STEP_W'(NUM_OUT - 1);

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                sel_est_q, sel_est_d;
    logic                advance;
    logic                done_c;
    ctrl_t               ctrl;

    interp_step_decode u_decode (
        .state (state_q),
        .step  (step_q),
        .ctrl  (ctrl)
    );

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        sel_est_d = sel_est_q;
        advance   = 1'b0;
        done_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = PREP;
                    step_d    = '0;
                    sel_est_d = shift_sel;
                end
            end
            PREP: begin
                advance = 1'b1;
                if (step_q == LAST_PREP) begin
                    state_d = EMIT;
                    step_d  = '0;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            EMIT: begin
                if (out_ready) begin
                    advance = 1'b1;
                    if (step_q == LAST_OUT) begin
                        done_c  = 1'b1;
                        state_d = IDLE;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                step_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            step_q    <= '0;
            sel_est_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            sel_est_q <= sel_est_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == EMIT);
    assign pair_idx  = out_valid ? step_q : '0;
    // A reset cycle abandons the set, so the last handshake must not report done.
    assign done      = done_c & rst;
    assign start_err = start & busy & rst;
    assign sel_est   = sel_est_q & busy;

    assign s1a  = ctrl.s1a;
    assign s1b  = ctrl.s1b;
    assign s2a  = ctrl.s2a;
    assign s2b  = ctrl.s2b;
    assign s_h1 = ctrl.s_h1;
    assign s_h2 = ctrl.s_h2;

    // Loads only on an advancing step, so a stalled 5E accumulate never repeats.
    assign en_reg_E  = ctrl.en_E  & advance;
    assign en_reg_2E = ctrl.en_2E & advance;
    assign en_reg_5E = ctrl.en_5E & advance;

`ifdef INTERP_SEQ_STALL_CNT_EN
    logic [STALL_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == IDLE && start) begin
            stall_d = '0;
        end else if (state_q == EMIT && !out_ready && stall_q != '1) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_interp_seq_ctrl.sv
// Scoreboard bench for interp_seq_ctrl: stimulus queues expected control words, a negedge monitor pops them.
module tb_interp_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        shift_sel = 1'b0;
    logic        out_ready = 1'b0;
    logic        busy, out_valid, done, start_err, sel_est;
    logic [2:0]  pair_idx, s1a, s1b, s2a, s2b;
    logic [1:0]  s_h1, s_h2;
    logic        en_reg_E, en_reg_2E, en_reg_5E;
`ifdef INTERP_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    interp_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .shift_sel (shift_sel),
        .out_ready (out_ready),
        .busy      (busy),
        .out_valid (out_valid),
        .pair_idx  (pair_idx),
        .done      (done),
        .start_err (start_err),
        .s1a       (s1a),
        .s1b       (s1b),
        .s2a       (s2a),
        .s2b       (s2b),
        .s_h1      (s_h1),
        .s_h2      (s_h2),
        .sel_est   (sel_est),
        .en_reg_E  (en_reg_E),
        .en_reg_2E (en_reg_2E),
        .en_reg_5E (en_reg_5E)
`ifdef INTERP_SEQ_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;
    logic [23:0] prep_q [$];
    logic [23:0] emit_q [$];
    logic [23:0] dut_w;

    // Field layout: pair_idx, s1a, s1b, s2a, s2b, s_h1, s_h2, {en_E,en_2E,en_5E}, sel_est, done
    assign dut_w = {pair_idx, s1a, s1b, s2a, s2b, s_h1, s_h2,
                    en_reg_E, en_reg_2E, en_reg_5E, sel_est, done};

    int EXP_S1A [6] = '{1, 1, 2, 3, 3, 4};
    int EXP_S1B [6] = '{0, 6, 5, 0, 6, 5};
    int EXP_S2A [6] = '{1, 2, 2, 3, 4, 4};
    int EXP_S2B [6] = '{5, 0, 6, 5, 0, 7};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic logic [23:0] mkw(input int idx, input int a1, input int b1, input int a2,
                                        input int b2, input int h1, input int h2, input int en,
                                        input int sel, input int dn);
        mkw = {idx[2:0], a1[2:0], b1[2:0], a2[2:0], b2[2:0], h1[1:0], h2[1:0],
               en[2:0], sel[0], dn[0]};
    endfunction

    task automatic push_set(input int sel);
        prep_q.push_back(mkw(0, 2, 1, 2, 1, 0, 0, 3'b110, sel, 0));
        prep_q.push_back(mkw(0, 6, 6, 5, 0, 0, 0, 3'b001, sel, 0));
        for (int i = 0; i < 6; i++) begin
            emit_q.push_back(mkw(i, EXP_S1A[i], EXP_S1B[i], EXP_S2A[i], EXP_S2B[i],
                                 1, 2, 0, sel, (i == 5) ? 1 : 0));
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (done) done_cnt++;
            if (!busy) begin
                chk("idle_outputs", 32'({out_valid, start_err, dut_w}), 32'd0);
            end else if (!out_valid) begin
                if (prep_q.size() == 0) flag_fail("prep_unexpected");
                else chk("prep_row", 32'(dut_w), 32'(prep_q.pop_front()));
            end else if (emit_q.size() == 0) begin
                flag_fail("emit_unexpected");
            end else if (out_ready) begin
                chk("emit_pair", 32'(dut_w), 32'(emit_q.pop_front()));
            end else begin
                chk("stall_hold", 32'(dut_w), 32'(emit_q[0] & 24'hFFFFFE));
            end
        end
    end

    task automatic run_seq(input int sel, input int stall_at, input int stall_len,
                           input int err_at, input int rst_at, input int exp_done_cyc,
                           input int exp_stall);
        int n;
        int first;
        int stall_left;
        int done0;
        bit got_done;
        bit err_done;
        push_set(sel);
        stall_left = stall_len;
        first      = 0;
        got_done   = 1'b0;
        err_done   = 1'b0;
        done0      = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; shift_sel = sel[0]; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; shift_sel = ~sel[0];
        n = 1;
        while (!got_done && n <= 40) begin
            if (n > 1) begin
                @(posedge clk); #1;
            end
            if (out_valid && int'(pair_idx) == stall_at && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            start = 1'b0;
            if (out_valid && int'(pair_idx) == err_at && !err_done) begin
                start    = 1'b1;
                err_done = 1'b1;
            end
            if (out_valid && int'(pair_idx) == rst_at) begin
                rst = 1'b0;
                @(posedge clk); #1;
                rst = 1'b1;
                prep_q.delete();
                emit_q.delete();
                @(negedge clk);
                chk("reset_clears", 32'({busy, out_valid, done, start_err, dut_w}), 32'd0);
                chk("reset_no_done", done_cnt - done0, 0);
`ifdef INTERP_SEQ_STALL_CNT_EN
                chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
                return;
            end
            @(negedge clk);
            chk("busy_in_seq", 32'(busy), 32'd1);
            chk("start_err", 32'(start_err), 32'(start));
            if (out_valid && first == 0) first = n;
            if (done) begin
                got_done = 1'b1;
                chk("done_cycle", n, exp_done_cyc);
            end
            n++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        if (!got_done) flag_fail("seq_timeout");
        chk("first_valid_cycle", first, 3);
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("one_done", done_cnt - done0, 1);
`ifdef INTERP_SEQ_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
`else
        if (exp_stall < 0) flag_fail("bad_stall_arg");
`endif
    endtask

    task automatic run_back_to_back();
        int n;
        int dones;
        int d_first;
        int d_second;
        push_set(0);
        push_set(0);
        dones = 0; d_first = 0; d_second = 0;
        @(posedge clk); #1;
        start = 1'b1; shift_sel = 1'b0; out_ready = 1'b1;
        n = 0;
        while (dones < 2 && n < 60) begin
            @(posedge clk); #1;
            n++;
            @(negedge clk);
            chk("b2b_start_err", 32'(start_err), 32'(busy));
            if (done) begin
                dones++;
                if (dones == 1) d_first = n;
                else d_second = n;
            end
        end
        start = 1'b0;
        if (dones < 2) flag_fail("b2b_timeout");
        chk("b2b_first_done", d_first, 8);
        chk("b2b_second_done", d_second, 17);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_idle_after", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("reset_idle", 32'({busy, out_valid, done, start_err, dut_w}), 32'd0);
        end
`ifdef INTERP_SEQ_STALL_CNT_EN
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        run_seq(1, -1, 0, -1, -1,  8, 0);   // nominal
        run_seq(0,  2, 4, -1, -1, 12, 4);   // backpressure at pair 2
        run_seq(1, -1, 0,  3, -1,  8, 0);   // start while busy
        run_seq(1, -1, 0, -1,  1,  0, 0);   // reset mid-sequence
        run_seq(0, -1, 0, -1, -1,  8, 0);   // full run after reset
        run_back_to_back();
        repeat (3) @(posedge clk);
        chk("queues_drained", 32'(prep_q.size() + emit_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
